// File: rtl/sseg_pkg.sv
// Shared definitions for the serial seven-segment driver: frame geometry,
// controller states and the hex-to-segment table.
package sseg_pkg;

    localparam int FRAME_BITS = 64;
    localparam logic [7:0] BLANK_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Returns {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sseg_hex_decode.sv
// One digit: hex nibble plus decimal point to an active-low segment byte,
// forced fully dark while blanked.
module sseg_hex_decode
    import sseg_pkg::*;
(
    input  logic [3:0] hex_i,
    input  logic       dp_i,
    input  logic       blank_i,
    output logic [7:0] byte_o
);

    assign byte_o = blank_i ? BLANK_BYTE : {~dp_i, hex2seg(hex_i)};

endmodule

// File: rtl/sseg_dev.sv
// Serial driver for the 8-digit display: captures a frame on a Start rising
// edge and shifts it MSB-first into the external shift-register chain.
module sseg_dev
    import sseg_pkg::*;
#(
    parameter int HALF_PERIOD = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        Start,
    input  logic        flash,
    input  logic [31:0] Hexs,
    input  logic [7:0]  point,
    input  logic [7:0]  LES,
    output logic        seg_clk,
    output logic        seg_clrn,
    output logic        seg_sout,
    output logic        SEG_PEN
);

    localparam int DIV_W = $clog2(HALF_PERIOD) + 1;
    localparam logic [DIV_W-1:0] HALF_END = DIV_W'(HALF_PERIOD - 1);
    localparam logic [DIV_W-1:0] FULL_END = DIV_W'(2 * HALF_PERIOD - 1);
    localparam logic [5:0]       LAST_BIT = 6'(FRAME_BITS - 1);

    logic [FRAME_BITS-1:0] cap_w;

    for (genvar i = 0; i < 8; i++) begin : g_digit
        sseg_hex_decode u_dec (
            .hex_i   (Hexs[4*i+3:4*i]),
            .dp_i    (point[i]),
            .blank_i (LES[i] & flash),
            .byte_o  (cap_w[8*i+7:8*i])
        );
    end

    state_e                state_q, state_d;
    logic                  start_s1_q, start_s2_q;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [5:0]            bit_q, bit_d;
    logic                  clk_q, clk_d;
    logic                  sout_q, sout_d;
    logic                  pen_q, pen_d;
    logic                  clrn_q;
    logic                  start_edge;

    // Edge is seen one cycle after Start is first sampled high, so capture
    // lands on the following clk edge.
    assign start_edge = start_s1_q & ~start_s2_q;

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        div_d   = div_q;
        bit_d   = bit_q;
        clk_d   = clk_q;
        sout_d  = sout_q;
        pen_d   = pen_q;
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d = SHIFT;
                    frame_d = cap_w;
                    sout_d  = cap_w[FRAME_BITS-1];
                    div_d   = '0;
                    bit_d   = '0;
                    clk_d   = 1'b0;
                    pen_d   = 1'b0;
                end
            end
            SHIFT: begin
                div_d = div_q + DIV_W'(1);
                if (div_q == HALF_END) clk_d = 1'b1;
                if (div_q == FULL_END) begin
                    div_d = '0;
                    clk_d = 1'b0;
                    if (bit_q == LAST_BIT) begin
                        state_d = DONE;
                        sout_d  = 1'b0;
                        pen_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 6'd1;
                        frame_d = {frame_q[FRAME_BITS-2:0], 1'b0};
                        sout_d  = frame_q[FRAME_BITS-2];
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            start_s1_q <= 1'b0;
            start_s2_q <= 1'b0;
            div_q      <= '0;
            bit_q      <= '0;
            clk_q      <= 1'b0;
            sout_q     <= 1'b0;
            pen_q      <= 1'b0;
            clrn_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_s1_q <= Start;
            start_s2_q <= start_s1_q;
            div_q      <= div_d;
            bit_q      <= bit_d;
            clk_q      <= clk_d;
            sout_q     <= sout_d;
            pen_q      <= pen_d;
            clrn_q     <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        frame_q <= frame_d;
    end

    assign seg_clk  = clk_q;
    assign seg_sout = sout_q;
    assign seg_clrn = clrn_q;
    assign SEG_PEN  = pen_q;

endmodule

// File: tb/tb_sseg_dev.sv
// Directed bench for sseg_dev: reconstructs the serial stream on seg_clk
// rising edges and compares it to hand-computed frames.
module tb_sseg_dev;

    logic        clk = 1'b0;
    logic        rstn;
    logic        Start;
    logic        flash;
    logic [31:0] Hexs;
    logic [7:0]  point;
    logic [7:0]  LES;
    logic        seg_clk, seg_clrn, seg_sout, SEG_PEN;

    int          vectors = 0;
    int          miscompares = 0;
    int          edges = 0;
    logic [63:0] stream = '0;
    int          e0;
    int          lowcyc;
    bit          ok;

    sseg_dev #(.HALF_PERIOD(4)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .Start    (Start),
        .flash    (flash),
        .Hexs     (Hexs),
        .point    (point),
        .LES      (LES),
        .seg_clk  (seg_clk),
        .seg_clrn (seg_clrn),
        .seg_sout (seg_sout),
        .SEG_PEN  (SEG_PEN)
    );

    always #5 clk = ~clk;

    always @(posedge seg_clk) begin
        stream = {stream[62:0], seg_sout};
        edges  = edges + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulses Start for two cycles, then counts cycles with SEG_PEN low until it rises.
    task automatic run_frame(output int low, output bit done);
        low  = 0;
        done = 1'b0;
        @(negedge clk);
        Start = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i == 1) Start = 1'b0;
            if (!SEG_PEN) low++;
            else if (low > 0) begin
                done = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_pen(output bit done);
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (SEG_PEN) begin
                done = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        rstn  = 1'b1;
        Start = 1'b0;
        flash = 1'b0;
        Hexs  = '0;
        point = '0;
        LES   = '0;
        #2 rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({seg_clk, seg_sout, seg_clrn, SEG_PEN}), 64'h0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_clrn", 64'(seg_clrn), 64'h1);
        check("post_reset_pen", 64'(SEG_PEN), 64'h0);
        check("post_reset_segclk", 64'(seg_clk), 64'h0);
        check("post_reset_no_edges", 64'(edges), 64'h0);

        // Basic frame
        Hexs = 32'h0300_0005; point = 8'b0100_0001; LES = 8'h00; flash = 1'b1;
        e0 = edges;
        run_frame(lowcyc, ok);
        check("basic_done", 64'(ok), 64'h1);
        check("basic_stream", stream, 64'hC030C0C0C0C0C012);
        check("basic_edges", 64'(edges - e0), 64'd64);
        check("basic_pen", 64'(SEG_PEN), 64'h1);
        check("basic_segclk_idle", 64'(seg_clk), 64'h0);

        // Blink, blank phase
        Hexs = 32'h1234_5678; point = 8'h00; LES = 8'h01; flash = 1'b1;
        run_frame(lowcyc, ok);
        check("blink_on_stream", stream, 64'hF9A4B0999282F8FF);
        check("blink_on_len", 64'(lowcyc), 64'd512);

        // Blink, lit phase
        flash = 1'b0;
        e0 = edges;
        run_frame(lowcyc, ok);
        check("blink_off_stream", stream, 64'hF9A4B0999282F880);
        check("blink_off_edges", 64'(edges - e0), 64'd64);

        // Start held high
        e0 = edges;
        @(negedge clk);
        Start = 1'b1;
        repeat (10000) @(negedge clk);
        check("held_one_frame", 64'(edges - e0), 64'd64);
        Start = 1'b0;
        repeat (5) @(negedge clk);

        // Second edge during SHIFT is dropped
        e0 = edges;
        @(negedge clk);
        Start = 1'b1;
        repeat (2) @(negedge clk);
        Start = 1'b0;
        repeat (100) @(negedge clk);
        Start = 1'b1;
        repeat (3) @(negedge clk);
        Start = 1'b0;
        wait_pen(ok);
        check("midshift_done", 64'(ok), 64'h1);
        repeat (600) @(negedge clk);
        check("midshift_ignored", 64'(edges - e0), 64'd64);
        check("midshift_idle_pen", 64'(SEG_PEN), 64'h1);
        run_frame(lowcyc, ok);
        check("midshift_fresh_edge", 64'(edges - e0), 64'd128);

        // Inputs change during SHIFT
        Hexs = 32'hABCD_EF01; point = 8'hFF; LES = 8'h00; flash = 1'b0;
        @(negedge clk);
        Start = 1'b1;
        repeat (2) @(negedge clk);
        Start = 1'b0;
        repeat (200) @(negedge clk);
        Hexs = 32'h0; point = 8'h00; LES = 8'hFF; flash = 1'b1;
        wait_pen(ok);
        check("stable_stream", stream, 64'h08034621060E4079);

        // Reset mid-frame
        Hexs = 32'h1234_5678; point = 8'h00; LES = 8'h00; flash = 1'b0;
        e0 = edges;
        @(negedge clk);
        Start = 1'b1;
        repeat (2) @(negedge clk);
        Start = 1'b0;
        for (int i = 0; i < 3000 && (edges - e0) < 20; i++) @(negedge clk);
        check("midreset_reached_20", 64'(edges - e0), 64'd20);
        rstn = 1'b0;
        #1;
        check("midreset_outputs", 64'({seg_clk, seg_sout, seg_clrn, SEG_PEN}), 64'h0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_pen_low", 64'(SEG_PEN), 64'h0);
        e0 = edges;
        run_frame(lowcyc, ok);
        check("midreset_done", 64'(ok), 64'h1);
        check("midreset_stream", stream, 64'hF9A4B0999282F880);
        check("midreset_edges", 64'(edges - e0), 64'd64);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sseg_dev.md
# sseg_dev

Serial driver for the board's 8-digit seven-segment display. It converts a 32-bit hexadecimal value into 64 segment bits: eight digits, each with seven segments plus a decimal point. It shifts those bits out over a clocked serial link into the display's external shift-register chain. It sits at the top level next to the VGA path, is refreshed by a slow strobe, and shows score and health values.

## Interface
Parameters:
- HALF_PERIOD, default 4: `clk` cycles per half period of `seg_clk`; legal range is 1 or more.

Ports:
- clk  in  1: system clock; single clock domain.
- rstn  in  1: reset; asynchronous, active-low.
- Start  in  1: refresh strobe, slow and level-type; a rising edge requests one frame.
- flash  in  1: blink phase; 1 is the blank phase.
- Hexs  in  32: eight hex digits; digit i is Hexs[4i+3:4i], and digit 0 is rightmost.
- point  in  8: point[i]=1 lights the decimal point of digit i.
- LES  in  8: LES[i]=1 makes digit i blink.
- seg_clk  out  1: serial shift clock.
- seg_clrn  out  1: active-low clear to the external chain.
- seg_sout  out  1: serial data.
- SEG_PEN  out  1: display output enable, active-high.

## Operation
- Segment byte for digit i is {dp, g, f, e, d, c, b, a}, active-low (0 = lit).
  - dp = ~point[i].
  - Bits [6:0] by hex value: 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E.
  - Full-byte examples: 0 with dp off = C0, 5 with dp on = 12.
- Blanking: if LES[i] & flash at capture time, the byte for digit i is FF; the decimal point is blanked too.
- Frame: 64 bits = {byte7, byte6, …, byte0}, shifted MSB first, so bit 63 goes out first.
- States:
  - IDLE: wait for a Start rising edge, detected from a registered copy of Start. On the edge, capture Hexs/point/LES/flash into the 64-bit frame register and go to SHIFT.
  - SHIFT: send 64 bits, then go to DONE.
  - DONE: one cycle; raise SEG_PEN, return to IDLE.
- Inputs are sampled only at capture; changes during SHIFT do not affect the frame in progress.
- A Start edge during SHIFT or DONE is ignored and is not queued.
- Start held high produces exactly one frame.
- SEG_PEN is 0 from reset until the first frame completes. It is 0 throughout SHIFT and 1 otherwise.
- seg_clrn is 0 in reset and 1 from the first clk edge after release.

## Timing
- Reset values: seg_clk=0, seg_sout=0, seg_clrn=0, SEG_PEN=0, state=IDLE, edge-detect register=0.
- Start detection: a Start rising edge sampled at clk edge n causes capture at edge n+1, which is also the SHIFT entry.
- Bit k (k=0..63):
  - seg_sout is updated to frame[63-k] while seg_clk=0.
  - seg_clk stays low for HALF_PERIOD cycles, then high for HALF_PERIOD cycles.
  - The external chain samples on the seg_clk rising edge; data is stable for HALF_PERIOD cycles before and after that edge.
- Frame length: 64·2·HALF_PERIOD cycles in SHIFT, followed by 1 DONE cycle. After the last bit, seg_clk returns to 0.
- Reset mid-frame: all outputs return immediately to their reset values and the frame is abandoned. The next Start edge after release sends a full frame.
- Counters: a bit counter (6 bits, or 7 with a terminal flag) and a divider of width ceil(log2(HALF_PERIOD))+1. Both wrap only through state transitions.

## Structure
- Package sseg_pkg:
  - hex-to-segment function/constant table (16×7);
  - BLANK_BYTE = 8'hFF;
  - FRAME_BITS = 64;
  - state enum {IDLE, SHIFT, DONE}.
- One sub-module, sseg_hex_decode: combinational 4-bit hex, dp, blank → 8-bit byte. Instantiate it 8 times in a generate loop.
- Top: edge detect, capture register, divider, bit counter, FSM, output registers. All outputs are registered.

## Test plan
- Reset: hold rstn=0 → all four outputs are 0. Release with no Start → seg_clrn=1, SEG_PEN=0, seg_clk idle low.
- Basic frame: Hexs=32'h0300_0005, point=8'b0100_0001, LES=0, flash=1, one Start pulse → captured stream equals C0 30 C0 C0 C0 C0 C0 12. It has exactly 64 seg_clk rising edges, and SEG_PEN=1 after DONE.
- Blink: Hexs=32'h1234_5678, LES=8'h01.
  - flash=1 → last byte is FF.
  - flash=0 → last byte is 80 (the byte for 8).
- Start handling:
  - Start held high for 10000 cycles → exactly one frame.
  - A second Start edge mid-SHIFT → ignored; the next frame occurs only after a fresh edge in IDLE.
- Input stability: change Hexs mid-SHIFT → the frame carries the captured value only.
- Reset mid-frame: assert rstn=0 after 20 bits → outputs are at reset values immediately. A later Start sends a complete, correct 64-bit frame.
